// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin (mod 2^N), LSB first, one bit per cycle.
// Define SERIAL_SUBTRACTOR_OVF_EN to build the signed-overflow flag; otherwise ovf is tied low.
//
// state | meaning
// IDLE  | waiting for start; operands captured on the accept edge
// SHIFT | one difference bit per cycle, N cycles
// DONE  | publish diff/bout/ovf, pulse done, return to IDLE
module serial_subtractor #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] diff,
  output logic         bout,
  output logic         ovf
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   a_q, a_d, b_q, b_d;
  logic [N-1:0]   sr_q, sr_d;
  logic [N-1:0]   diff_q, diff_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           br_q, br_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           bout_q, bout_d;
  logic           d_bit, br_next;

`ifdef SERIAL_SUBTRACTOR_OVF_EN
  // Operand sign bits are kept aside because a_q/b_q are consumed by the shift.
  logic a_msb_q, a_msb_d, b_msb_q, b_msb_d;
  logic ovf_q, ovf_d;
`endif

  assign d_bit   = a_q[0] ^ b_q[0] ^ br_q;
  assign br_next = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sr_d    = sr_q;
    diff_d  = diff_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    bout_d  = bout_q;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          br_d    = bin;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = SHIFT;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
          a_msb_d = a[N-1];
          b_msb_d = b[N-1];
`endif
        end
      end
      SHIFT: begin
        sr_d  = {d_bit, sr_q[N-1:1]};
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        br_d  = br_next;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        diff_d  = sr_q;
        bout_d  = br_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        ovf_d   = (a_msb_q != b_msb_q) && (sr_q[N-1] != a_msb_q);
`endif
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sr_q    <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bout_q  <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sr_q    <= sr_d;
      diff_q  <= diff_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      bout_q  <= bout_d;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  assign ovf  = ovf_q;
`else
  assign ovf  = 1'b0;
`endif

endmodule
